png_packet_assembler: RTL

- Upstream stage of the PNG byte-shift buffer.
- Accepts a byte stream from the UDP receive path, with destination IP/port sideband.
- Filters packets by IP/port and packs accepted payload bytes MSB-first into a FRAME_BYTES-wide word.
- Presents each word with a valid/ready handshake; the consumer loads it and shifts bytes out from bit [FRAME_BYTES*8-1] downward.

---
 rtl/png_packet_assembler.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/png_packet_assembler.sv
// Byte-stream to frame-word packer with optional IP/port filter.
// Optional feature macro: PKT_FILTER_EN (IP/port filter, DISCARD, drop_count).
module png_packet_assembler #(
  parameter int          FRAME_BYTES = 69,
  parameter logic [31:0] FILTER_IP   = 32'hC0A80001,
  parameter logic [15:0] FILTER_PORT = 16'd5000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  input  logic [7:0]               s_data,
  input  logic                     s_last,
  output logic                     s_ready,
  input  logic [31:0]              pkt_ip,
  input  logic [15:0]              pkt_port,
  output logic [FRAME_BYTES*8-1:0] frame_data,
  output logic [6:0]               frame_bytes,
  output logic                     frame_last,
  output logic                     frame_valid,
  input  logic                     frame_ready,
  output logic [15:0]              drop_count
);

  localparam int W = FRAME_BYTES * 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
`ifdef PKT_FILTER_EN
    , DISCARD = 2'd3
`endif
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   data_q, data_d;
  logic [6:0]     cnt_q, cnt_d;
  logic           last_q, last_d;
  logic           accept;
  logic           match;
  logic           wen;
  logic [6:0]     wslot;

`ifdef PKT_FILTER_EN
  logic [15:0]    drop_q, drop_d;
  assign match      = (pkt_ip == FILTER_IP) && (pkt_port == FILTER_PORT);
  assign drop_count = drop_q;
`else
  logic           unused_sideband;
  assign match           = 1'b1;
  assign unused_sideband = ^{pkt_ip, pkt_port};
  assign drop_count      = '0;
`endif

  assign accept      = s_valid && (state_q != HOLD);
  assign s_ready     = (state_q != HOLD);
  assign frame_valid = (state_q == HOLD);
  assign frame_data  = data_q;
  assign frame_bytes = cnt_q;
  assign frame_last  = last_q;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    wen     = 1'b0;
    wslot   = cnt_q;
`ifdef PKT_FILTER_EN
    drop_d  = drop_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (match) begin
            data_d = '0;
            wen    = 1'b1;
            wslot  = 7'd0;
            cnt_d  = 7'd1;
            last_d = s_last;
            if (s_last || FRAME_BYTES == 1) state_d = HOLD;
            else                            state_d = COLLECT;
          end
`ifdef PKT_FILTER_EN
          else begin
            if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
            state_d = s_last ? IDLE : DISCARD;
          end
`endif
        end
      end
      COLLECT: begin
        if (accept) begin
          wen    = 1'b1;
          cnt_d  = cnt_q + 7'd1;
          last_d = s_last;
          if (s_last || cnt_q == 7'(FRAME_BYTES - 1)) state_d = HOLD;
        end
      end
`ifdef PKT_FILTER_EN
      DISCARD: begin
        if (accept && s_last) state_d = IDLE;
      end
`endif
      HOLD: begin
        if (frame_ready) begin
          if (last_q) begin
            state_d = IDLE;
          end else begin
            // packet continues: next frame starts from an empty word
            state_d = COLLECT;
            cnt_d   = 7'd0;
            data_d  = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    for (int k = 0; k < FRAME_BYTES; k++) begin
      if (wen && wslot == 7'(k)) data_d[W-1-8*k -: 8] = s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
`ifdef PKT_FILTER_EN
      drop_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
`ifdef PKT_FILTER_EN
      drop_q  <= drop_d;
`endif
    end
  end

endmodule
